// File: rtl/venus_decode_pkg.sv
// Shared constants and instruction decode for the decode/queue stage.
package venus_decode_pkg;

    localparam int DEF_WORD  = 32;
    localparam int DEF_ADDR  = 32;
    localparam int DEF_W_RD  = 5;
    localparam int DEF_W_IMM = 16;
    localparam int DEF_W_OPC = 5;
    localparam int DEF_W_OPR = 32;
    localparam int DEF_DEPTH = 4;

    // Decode-info vector layout
    localparam int D_INFO_W = 3;
    localparam int D_WREG   = 0;
    localparam int D_SIGNED = 1;
    localparam int D_IMMF   = 2;

    // Opcode map (value of the top W_OPC bits of the instruction)
    localparam logic [31:0] OPC_ADD  = 32'd1;  // rd <- rs op rt
    localparam logic [31:0] OPC_ADDI = 32'd2;  // rd <- rs op sext(imm)
    localparam logic [31:0] OPC_ORI  = 32'd3;  // rd <- rs op zext(imm)
    localparam logic [31:0] OPC_ST   = 32'd4;  // store, sext(imm) offset
    localparam logic [31:0] OPC_BR   = 32'd5;  // branch, sext(imm) offset

    // field holds inst[WORD-1 : 2*W_RD+W_IMM] right-aligned; the opcode
    // is its top opc_w bits, the remaining low bits are ignored here.
    function automatic logic [D_INFO_W-1:0] decode_inst(
        input logic [31:0] field,
        input int unsigned field_w,
        input int unsigned opc_w
    );
        logic [31:0]         opc;
        logic [D_INFO_W-1:0] info;
        opc  = field >> (field_w - opc_w);
        info = '0;
        case (opc)
            OPC_ADD:  info = 3'b001;
            OPC_ADDI: info = 3'b111;
            OPC_ORI:  info = 3'b101;
            OPC_ST:   info = 3'b110;
            OPC_BR:   info = 3'b110;
            default:  info = 3'b000;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/decode_fifo.sv
// Instruction queue: DEPTH-entry {inst, pc} store with count and flush.
module decode_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              full_o,
    output logic              empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_ok, pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i & ~full_o & ~flush_i;
    assign pop_ok  = pop_i & ~empty_o & ~flush_i;
    assign rdata_o = mem[rd_ptr_q];

    // Next pointers/count; pointers wrap naturally since DEPTH is 2^PTR_W
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push_ok && !pop_ok)      count_d = count_q + CNT_W'(1);
            else if (pop_ok && !push_ok) count_d = count_q - CNT_W'(1);
        end
    end

    // Pointer and count registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/decode_queue_stage.sv
// Decode stage: instruction queue followed by one registered decode slot.
// Optional DECODE_QUEUE_BYPASS_EN lets an input go straight into a free
// slot when the queue is empty (1-edge latency instead of 2).
module decode_queue_stage
    import venus_decode_pkg::*;
#(
    parameter int WORD  = DEF_WORD,
    parameter int ADDR  = DEF_ADDR,
    parameter int W_RD  = DEF_W_RD,
    parameter int W_IMM = DEF_W_IMM,
    parameter int W_OPC = DEF_W_OPC,
    parameter int W_OPR = DEF_W_OPR,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             v_i,
    output logic             stall_o,
    input  logic [WORD-1:0]  inst_i,
    input  logic [ADDR-1:0]  pc_i,
    input  logic             branch_i,
    input  logic             stall_i,
    input  logic             reserved_i,
    output logic [W_RD-1:0]  r0_o,
    output logic [W_RD-1:0]  r1_o,
    input  logic [W_OPR-1:0] r_opr0_i,
    input  logic [W_OPR-1:0] r_opr1_i,
    output logic             v_o,
    output logic [W_OPC-1:0] opecode_o,
    output logic [W_OPR-1:0] opr0_o,
    output logic [W_OPR-1:0] opr1_o,
    output logic [W_OPR-1:0] imm_o,
    output logic [ADDR-1:0]  pc_o,
    output logic             w_reserve_o,
    output logic             wb_o,
    output logic [W_RD-1:0]  wb_r_o
);
    localparam int HI_LSB = 2 * W_RD + W_IMM;
    localparam int HI_W   = WORD - HI_LSB;
    localparam int Q_W    = WORD + ADDR;

    logic [Q_W-1:0]      fifo_rdata;
    logic                fifo_full, fifo_empty, fifo_push;
    logic                push_acc, fire, slot_free, load_q, bypass, load;
    logic [WORD-1:0]     ld_inst;
    logic [ADDR-1:0]     ld_pc;
    logic [D_INFO_W-1:0] ld_info;
    logic [W_IMM-1:0]    ld_imm;
    logic [W_OPR-1:0]    ld_imm_ext;

    logic             v_r_q, v_r_d;
    logic [W_OPC-1:0] opc_q, opc_d;
    logic [W_RD-1:0]  r0_q, r0_d, r1_q, r1_d;
    logic [ADDR-1:0]  pc_q, pc_d;
    logic [W_OPR-1:0] imm_q, imm_d;
    logic             immf_q, immf_d, wreg_q, wreg_d;

    assign stall_o   = fifo_full;
    assign push_acc  = v_i & ~fifo_full & ~branch_i;
    assign fire      = v_r_q & ~reserved_i & ~stall_i;
    assign slot_free = ~v_r_q | fire;
    assign load_q    = ~fifo_empty & slot_free;
`ifdef DECODE_QUEUE_BYPASS_EN
    assign bypass    = fifo_empty & ~branch_i & slot_free & push_acc;
`else
    assign bypass    = 1'b0;
`endif
    assign fifo_push = push_acc & ~bypass;
    assign load      = (load_q | bypass) & ~branch_i;

    decode_fifo #(.DATA_W(Q_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .flush_i (branch_i),
        .push_i  (fifo_push),
        .pop_i   (load_q),
        .wdata_i ({inst_i, pc_i}),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Select slot source and decode it; the immediate is extended here
    always_comb begin
        if (bypass) begin
            ld_inst = inst_i;
            ld_pc   = pc_i;
        end else begin
            ld_inst = fifo_rdata[Q_W-1 -: WORD];
            ld_pc   = fifo_rdata[ADDR-1:0];
        end
        ld_info = decode_inst(32'(ld_inst[WORD-1 -: HI_W]), HI_W, W_OPC);
        ld_imm  = ld_inst[W_IMM-1:0];
        if (ld_info[D_SIGNED]) ld_imm_ext = W_OPR'($signed(ld_imm));
        else                   ld_imm_ext = W_OPR'(ld_imm);
    end

    // Slot next state: flush beats load, load beats drain-on-fire
    always_comb begin
        v_r_d  = v_r_q;
        opc_d  = opc_q;
        r0_d   = r0_q;
        r1_d   = r1_q;
        pc_d   = pc_q;
        imm_d  = imm_q;
        immf_d = immf_q;
        wreg_d = wreg_q;
        if (branch_i) begin
            v_r_d = 1'b0;
        end else if (load) begin
            v_r_d  = 1'b1;
            opc_d  = ld_inst[WORD-1 -: W_OPC];
            r0_d   = ld_inst[HI_LSB-1 -: W_RD];
            r1_d   = ld_inst[W_RD+W_IMM-1 -: W_RD];
            pc_d   = ld_pc;
            imm_d  = ld_imm_ext;
            immf_d = ld_info[D_IMMF];
            wreg_d = ld_info[D_WREG];
        end else if (fire) begin
            v_r_d = 1'b0;
        end
    end

    // Slot registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_r_q  <= 1'b0;
            opc_q  <= '0;
            r0_q   <= '0;
            r1_q   <= '0;
            pc_q   <= '0;
            imm_q  <= '0;
            immf_q <= 1'b0;
            wreg_q <= 1'b0;
        end else begin
            v_r_q  <= v_r_d;
            opc_q  <= opc_d;
            r0_q   <= r0_d;
            r1_q   <= r1_d;
            pc_q   <= pc_d;
            imm_q  <= imm_d;
            immf_q <= immf_d;
            wreg_q <= wreg_d;
        end
    end

    assign r0_o        = r0_q;
    assign r1_o        = r1_q;
    assign opecode_o   = opc_q;
    assign pc_o        = pc_q;
    assign imm_o       = imm_q;
    assign opr0_o      = r_opr0_i;
    assign opr1_o      = immf_q ? imm_q : r_opr1_i;
    assign v_o         = v_r_q & ~reserved_i;
    assign w_reserve_o = fire & wreg_q;
    assign wb_o        = fire & wreg_q;
    assign wb_r_o      = r0_q;

endmodule

// File: tb/tb_decode_queue_stage.sv
// Scoreboard bench for decode_queue_stage: stimulus pushes expected issue
// records, a negedge monitor pops and compares on every fire cycle.
module tb_decode_queue_stage;

`ifdef DECODE_QUEUE_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        reset, v_i, stall_o, branch_i, stall_i, reserved_i;
    logic [31:0] inst_i, pc_i, r_opr0_i, r_opr1_i;
    logic [4:0]  r0_o, r1_o, opecode_o, wb_r_o;
    logic        v_o, w_reserve_o, wb_o;
    logic [31:0] opr0_o, opr1_o, imm_o, pc_o;

    always #5 clk = ~clk;

    decode_queue_stage dut (
        .clk(clk), .reset(reset), .v_i(v_i), .stall_o(stall_o),
        .inst_i(inst_i), .pc_i(pc_i), .branch_i(branch_i), .stall_i(stall_i),
        .reserved_i(reserved_i), .r0_o(r0_o), .r1_o(r1_o),
        .r_opr0_i(r_opr0_i), .r_opr1_i(r_opr1_i), .v_o(v_o),
        .opecode_o(opecode_o), .opr0_o(opr0_o), .opr1_o(opr1_o),
        .imm_o(imm_o), .pc_o(pc_o), .w_reserve_o(w_reserve_o),
        .wb_o(wb_o), .wb_r_o(wb_r_o)
    );

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  opc;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [31:0] imm;
        logic        wreg;
        logic        immf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    // Hand-encoded vectors: [31:27] opc, [26] spare, [25:21] r0, [20:16] r1, [15:0] imm
    logic [31:0] vec_inst [6] = '{32'h08640000, 32'h10A6FFF0, 32'h18E8FFF0,
                                  32'h212A0010, 32'h2BE18000, 32'h04421234};
    logic [4:0]  vec_opc  [6] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd0};
    logic [4:0]  vec_r0   [6] = '{5'd3, 5'd5, 5'd7, 5'd9, 5'd31, 5'd2};
    logic [4:0]  vec_r1   [6] = '{5'd4, 5'd6, 5'd8, 5'd10, 5'd1, 5'd2};
    logic [31:0] vec_imm  [6] = '{32'h00000000, 32'hFFFFFFF0, 32'h0000FFF0,
                                  32'h00000010, 32'hFFFF8000, 32'h00001234};
    logic        vec_wreg [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        vec_immf [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t make_exp(input int vi, input logic [31:0] pc);
        exp_t e;
        e.pc = pc; e.opc = vec_opc[vi]; e.r0 = vec_r0[vi]; e.r1 = vec_r1[vi];
        e.imm = vec_imm[vi]; e.wreg = vec_wreg[vi]; e.immf = vec_immf[vi];
        return e;
    endfunction

    // Monitor: every fire cycle must match the oldest expected record
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en && !reset) begin
                if (v_o && !stall_i) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL ghost_issue: pc %h issued, none expected", pc_o);
                    end else begin
                        e = exp_q.pop_front();
                        check("pc", pc_o, e.pc);
                        check("opcode", opecode_o, e.opc);
                        check("r0", r0_o, e.r0);
                        check("r1", r1_o, e.r1);
                        check("imm", imm_o, e.imm);
                        check("opr0", opr0_o, r_opr0_i);
                        check("opr1", opr1_o, e.immf ? e.imm : r_opr1_i);
                        check("wb", wb_o, e.wreg);
                        check("w_reserve", w_reserve_o, e.wreg);
                        check("wb_r", wb_r_o, e.r0);
                        $display("issue pc=%h opc=%0d r0=%0d r1=%0d imm=%h opr1=%h wb=%0b",
                                 pc_o, opecode_o, r0_o, r1_o, imm_o, opr1_o, wb_o);
                    end
                end else begin
                    check("w_reserve_idle", w_reserve_o, 0);
                    check("wb_idle", wb_o, 0);
                end
            end
        end
    end

    // Offer one instruction until accepted (bounded)
    task automatic push_inst(input int vi, input logic [31:0] pc, input bit rand_stall);
        bit acc = 1'b0;
        v_i = 1'b1; inst_i = vec_inst[vi]; pc_i = pc;
        for (int t = 0; t < 60 && !acc; t++) begin
            @(negedge clk);
            acc = !stall_o && !branch_i;
            if (acc) exp_q.push_back(make_exp(vi, pc));
            @(posedge clk); #1;
            if (rand_stall) begin
                stall_i  = 1'($urandom_range(0, 1));
                r_opr1_i = $urandom;
            end
        end
        v_i = 1'b0;
        if (!acc) begin
            checks++; errors++;
            $display("FAIL push_timeout: pc %h never accepted, required acceptance", pc);
        end
    endtask

    task automatic drain();
        stall_i = 1'b0;
        for (int t = 0; t < 100 && exp_q.size() != 0; t++) begin
            @(posedge clk); #1;
        end
        check("drain_left", exp_q.size(), 0);
    endtask

    // Push into an idle stage and measure when v_o rises
    task automatic latency_check(input logic [31:0] pc);
        v_i = 1'b1; inst_i = vec_inst[0]; pc_i = pc;
        @(negedge clk);
        check("lat_accept_stall", stall_o, 0);
        exp_q.push_back(make_exp(0, pc));
        @(posedge clk); #1;
        v_i = 1'b0;
        @(negedge clk);
        check("lat_v_after_edge1", v_o, (LAT == 1) ? 1 : 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("lat_v_after_edge2", v_o, (LAT == 2) ? 1 : 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int n_acc;
        reset = 1'b1; v_i = 1'b0; branch_i = 1'b0; stall_i = 1'b0; reserved_i = 1'b0;
        inst_i = '0; pc_i = '0; r_opr0_i = 32'h12345678; r_opr1_i = 32'hDEADBEEF;
        repeat (2) @(posedge clk);
        #1;
        check("rst_v_o", v_o, 0);
        check("rst_stall_o", stall_o, 0);
        check("rst_w_reserve", w_reserve_o, 0);
        check("rst_wb", wb_o, 0);
        check("rst_opcode", opecode_o, 0);
        check("rst_r0", r0_o, 0);
        check("rst_r1", r1_o, 0);
        check("rst_wb_r", wb_r_o, 0);
        check("rst_imm", imm_o, 0);
        check("rst_pc", pc_o, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        mon_en = 1'b1;

        // Latency from idle
        latency_check(32'h100);
        drain();

        // Immediate / decode patterns back-to-back; opr1 source changed midway
        for (int k = 0; k < 6; k++) begin
            if (k == 3) r_opr1_i = 32'h0BADF00D;
            push_inst(k, 32'h180 + 32'(4 * k), 1'b0);
        end
        drain();

        // Hazard: reserved source holds the slot, then fires with writeback
        reserved_i = 1'b1;
        push_inst(0, 32'h200, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("hz_v_o", v_o, 0);
            check("hz_w_reserve", w_reserve_o, 0);
            @(posedge clk); #1;
        end
        reserved_i = 1'b0;
        #1;
        check("hz_v_comb_rise", v_o, 1);
        drain();

        // Fill: execute stalled, fetch pushes every cycle
        stall_i = 1'b1;
        n_acc = 0;
        for (int k = 0; k < 8; k++) begin
            v_i = 1'b1; inst_i = vec_inst[n_acc % 6]; pc_i = 32'(4 * n_acc);
            @(negedge clk);
            if (!stall_o) begin
                exp_q.push_back(make_exp(n_acc % 6, 32'(4 * n_acc)));
                n_acc++;
            end
            @(posedge clk); #1;
        end
        v_i = 1'b0;
        check("fill_accepted", n_acc, 5);
        @(negedge clk);
        check("fill_stall_o", stall_o, 1);
        @(posedge clk); #1;
        drain();

        // Flush: slot + 3 queued, branch with an offered input
        stall_i = 1'b1;
        for (int k = 0; k < 4; k++) push_inst(k, 32'h300 + 32'(4 * k), 1'b0);
        v_i = 1'b1; inst_i = vec_inst[1]; pc_i = 32'h3F0; branch_i = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        branch_i = 1'b0; v_i = 1'b0; stall_i = 1'b0;
        @(negedge clk);
        check("flush_v_o", v_o, 0);
        check("flush_stall_o", stall_o, 0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("flush_empty_v_o", v_o, 0);
        end
        @(posedge clk); #1;
        push_inst(2, 32'h400, 1'b0);
        drain();

        // Reset mid-stream with 3 entries queued
        stall_i = 1'b1;
        for (int k = 0; k < 4; k++) push_inst(k + 2, 32'h480 + 32'(4 * k), 1'b0);
        reset = 1'b1;
        #1;
        check("midrst_v_o", v_o, 0);
        check("midrst_stall_o", stall_o, 0);
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b0; stall_i = 1'b0;
        latency_check(32'h500);
        drain();

        // Wrap: 20 pushes with random execute stalls
        for (int k = 0; k < 20; k++) push_inst(k % 6, 32'h600 + 32'(4 * k), 1'b1);
        drain();

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/decode_queue_stage.md
# decode_queue_stage

Parametrised decode stage for the pipelined core: a DEPTH-entry instruction queue between fetch and decode, followed by one registered decode slot. Fetch can keep pushing while execute stalls or a source register is reserved, which removes the fetch-to-execute stall coupling. It also fixes immediate extension for any W_OPR and W_IMM, and flushes the whole queue on branch. The stage drives register-file read addresses and the operand and opcode bundle into execute.

## Interface
Parameters:
- WORD, 32, instruction width
- ADDR, 32, PC width
- W_RD, 5, register index width
- W_IMM, 16, immediate field width
- W_OPC, 5, opcode width, taken from inst[WORD-1 : WORD-W_OPC]
- W_OPR, 32, operand width; must be at least W_IMM
- DEPTH, 4, queue entries; must be a power of two and at least 2

Ports (all widths are the parameters above):
- clk  in  1  clock
- reset  in  1  asynchronous reset, active-high
- v_i  in  1  fetch offers inst_i/pc_i
- stall_o  out  1  queue full; fetch must hold
- inst_i  in  WORD  instruction
- pc_i  in  ADDR  instruction PC
- branch_i  in  1  flush request
- stall_i  in  1  execute cannot accept
- reserved_i  in  1  scoreboard: a source of the decode slot is pending
- r0_o, r1_o  out  W_RD  register-file read addresses for the slot
- r_opr0_i, r_opr1_i  in  W_OPR  register-file read data
- v_o  out  1  slot valid and issuable
- opecode_o  out  W_OPC  opcode
- opr0_o, opr1_o  out  W_OPR  operands
- imm_o  out  W_OPR  extended immediate
- pc_o  out  ADDR  slot PC
- w_reserve_o  out  1  reserve destination r0_o this cycle
- wb_o  out  1  issuing instruction writes back
- wb_r_o  out  W_RD  writeback register (= r0_o)

## Operation
- Field split: r0 = inst[2·W_RD+W_IMM-1 : W_RD+W_IMM]; r1 = inst[W_RD+W_IMM-1 : W_IMM]; imm = inst[W_IMM-1:0].
- Decoding: d_info = decode_inst(inst[WORD-1 : 2·W_RD+W_IMM]). Bit [0] = writes register, bit [1] = signed immediate, bit [2] = immediate operand.
- Enqueue: when v_i & ~stall_o & ~branch_i.
- stall_o = (count == DEPTH), taken from registered count. A simultaneous dequeue does not admit a push while full.
- Decode slot registers: v_r, opcode, r0, r1, pc, extended immediate, immf, wreg.
- fire = v_r & ~reserved_i & ~stall_i.
- The slot loads the queue head when the queue is non-empty and (~v_r | fire). Otherwise it holds every field.
- Immediate extension: imm_o = {W_OPR-W_IMM copies of imm[W_IMM-1] when signed, else zeros, imm}. Computed at load.
- Outputs:
  - opr0_o = r_opr0_i.
  - opr1_o = immf ? imm_o : r_opr1_i.
  - v_o = v_r & ~reserved_i.
  - w_reserve_o = fire & wreg.
  - wb_o = fire & wreg.
- Flush: branch_i clears count, pointers and v_r at the next edge. The input offered that cycle is dropped, and branch wins over every load or push.
- Reset mid-operation clears the queue and slot immediately. In-flight entries are lost.

## Timing
- Reset values: v_o 0, stall_o 0, w_reserve_o 0, wb_o 0. All registered data fields are 0, so opecode_o, r0_o, r1_o, wb_r_o, imm_o and pc_o are 0.
- Latency with an empty queue and a free slot: push at edge N, head load at edge N+1, v_o high in cycle N+1.
- Throughput: 1 instruction/cycle sustained.
- Queue pointers wrap modulo DEPTH.
- A push and a dequeue in the same cycle keep count unchanged.
- reserved_i deasserting makes v_o rise combinationally in the same cycle.

## Configuration
- DECODE_QUEUE_BYPASS_EN defined: when the queue is empty, ~branch_i and (~v_r | fire), an accepted input loads directly into the slot at edge N without entering the queue. Latency becomes 1 edge.
- Undefined: every instruction passes through the queue, with the 2-edge latency above.

## Structure
- Package venus_decode_pkg holds:
  - the default parameter constants;
  - D_INFO width and the bit indices for wreg, signed and immf;
  - the decode_inst function.
- Sub-module decode_fifo: {inst, pc} storage, pointers, count, full/empty, flush input.

## Test plan
- Reset: assert reset mid-stream with 3 entries queued → v_o=0 and stall_o=0 immediately; after release the next instruction appears 2 edges later (1 edge with bypass).
- Fill: stall_i=1 and v_i continuous → 1 entry in the slot plus DEPTH=4 in the queue, then stall_o=1. Release stall_i → PCs 0,4,8,… issue in order with none lost or duplicated.
- Immediate: signed-flag opcode with imm=0xFFF0 → imm_o=0xFFFFFFF0. Unsigned with imm=0xFFF0 → 0x0000FFF0. immf=1 → opr1_o=imm_o regardless of r_opr1_i.
- Hazard: reserved_i=1 for 3 cycles on a slot with a wreg instruction → v_o=0 and w_reserve_o=0 while held; pulse w_reserve_o=1 and wb_o=1 with wb_r_o=r0 on the fire cycle.
- Flush: branch_i with 3 queued, v_r=1 and v_i=1 → next cycle v_o=0, count=0, the offered instruction is absent, and the next push issues normally.
- Wrap: 20 single pushes with random stall_i → output order matches input, and count never exceeds 4.
